// File: rtl/fft_pkg.sv
// ============================================================================
// fft_pkg : shared types and scaled butterfly arithmetic for the 4-point FFT family
// Rev 1.0
// ============================================================================
`default_nettype none

package fft_pkg;

   localparam int DATA_W = 16;

   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_STG1   = 2'd1,
      ST_STG2   = 2'd2,
      ST_UNLOAD = 2'd3
   } state_t;

   // One guard bit absorbs the add/sub carry; dropping the LSB is an arithmetic
   // shift right by 1, so the result always fits back into DATA_W.
   function automatic logic signed [DATA_W-1:0] half_addsub(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b,
      input logic                     sub
   );
      logic signed [DATA_W:0] s;
      s = sub ? ({a[DATA_W-1], a} - {b[DATA_W-1], b})
              : ({a[DATA_W-1], a} + {b[DATA_W-1], b});
      return s[DATA_W:1];
   endfunction

endpackage

`default_nettype wire

// File: rtl/ifft_bf2.sv
// ============================================================================
// ifft_bf2 : combinational radix-2 inverse butterfly, twiddle 1 (tw=0) or +j (tw=1)
// Rev 1.0
// ============================================================================
`default_nettype none

module ifft_bf2
   import fft_pkg::*;
(
   input  cplx_t a,
   input  cplx_t b,
   input  logic  tw,
   output cplx_t p,
   output cplx_t m
);

   // j*b = (-b.im, b.re); folding the sign into the add/sub avoids negating -2^(W-1).
   always_comb begin
      if (tw) begin
         p.re = half_addsub(a.re, b.im, 1'b1);
         p.im = half_addsub(a.im, b.re, 1'b0);
         m.re = half_addsub(a.re, b.im, 1'b0);
         m.im = half_addsub(a.im, b.re, 1'b1);
      end else begin
         p.re = half_addsub(a.re, b.re, 1'b0);
         p.im = half_addsub(a.im, b.im, 1'b0);
         m.re = half_addsub(a.re, b.re, 1'b1);
         m.im = half_addsub(a.im, b.im, 1'b1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/ifft_point_4_seq.sv
// ============================================================================
// ifft_point_4_seq : streaming 4-point radix-2 inverse FFT with 1/N scaling
// Rev 1.0
// ============================================================================
`default_nettype none

module ifft_point_4_seq
   import fft_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_re,
   input  logic [DATA_W-1:0] in_im,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_re,
   output logic [DATA_W-1:0] out_im,
   output logic              out_last
);

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [1:0]       odx_q, odx_d;
   cplx_t [3:0]      x_q, x_d;     // input bins X0..X3
   cplx_t [3:0]      st1_q, st1_d; // A0, A1, B0, B1
   cplx_t [3:0]      y_q, y_d;     // time samples x0..x3

   cplx_t a0_w, a1_w, b0_w, b1_w;
   cplx_t y0_w, y1_w, y2_w, y3_w;

   ifft_bf2 u_bf_s1_a (.a(x_q[0]),   .b(x_q[2]),   .tw(1'b0), .p(a0_w), .m(a1_w));
   ifft_bf2 u_bf_s1_b (.a(x_q[1]),   .b(x_q[3]),   .tw(1'b0), .p(b0_w), .m(b1_w));
   ifft_bf2 u_bf_s2_e (.a(st1_q[0]), .b(st1_q[2]), .tw(1'b0), .p(y0_w), .m(y2_w));
   ifft_bf2 u_bf_s2_o (.a(st1_q[1]), .b(st1_q[3]), .tw(1'b1), .p(y1_w), .m(y3_w));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
         idx_q   <= '0;
         odx_q   <= '0;
         x_q     <= '0;
         st1_q   <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         odx_q   <= odx_d;
         x_q     <= x_d;
         st1_q   <= st1_d;
         y_q     <= y_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      odx_d     = odx_q;
      x_d       = x_q;
      st1_d     = st1_q;
      y_d       = y_q;
      in_ready  = (state_q == ST_LOAD);
      out_valid = (state_q == ST_UNLOAD);
      out_last  = out_valid && (odx_q == 2'd3);
      // Gate the data mux so the idle output reads zero, as it does out of reset.
      out_re    = out_valid ? y_q[odx_q].re : '0;
      out_im    = out_valid ? y_q[odx_q].im : '0;

      case (state_q)
         ST_LOAD: begin
            if (in_valid) begin
               x_d[idx_q] = {in_re, in_im};
               idx_d      = 2'(idx_q + 2'd1);
               if (idx_q == 2'd3) state_d = ST_STG1;
            end
         end
         ST_STG1: begin
            st1_d[0] = a0_w;
            st1_d[1] = a1_w;
            st1_d[2] = b0_w;
            st1_d[3] = b1_w;
            state_d  = ST_STG2;
         end
         ST_STG2: begin
            y_d[0]  = y0_w;
            y_d[1]  = y1_w;
            y_d[2]  = y2_w;
            y_d[3]  = y3_w;
            state_d = ST_UNLOAD;
         end
         ST_UNLOAD: begin
            if (out_ready) begin
               odx_d = 2'(odx_q + 2'd1);
               if (odx_q == 2'd3) state_d = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_ifft_point_4_seq.sv
// Directed bench for ifft_point_4_seq: impulse, single bin, full scale, truncation,
// backpressure with ignored input, and asynchronous reset during unload.
`default_nettype none

module tb_ifft_point_4_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_re = '0;
   logic [15:0] in_im = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_re;
   logic [15:0] out_im;
   logic        out_last;

   int pass_cnt  = 0;
   int total_cnt = 0;

   ifft_point_4_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_re    (in_re),
      .in_im    (in_im),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_re   (out_re),
      .out_im   (out_im),
      .out_last (out_last)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Drives one frame X0..X3 on consecutive cycles; returns at the negedge after the last handshake.
   task automatic send_frame(input logic [3:0][15:0] re, input logic [3:0][15:0] im);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         for (int w = 0; w < 50 && !in_ready; w++) @(negedge clk);
         in_valid = 1'b1;
         in_re    = re[i];
         in_im    = im[i];
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Collects four output samples with out_ready high; must be entered on a negedge.
   task automatic recv_frame(output logic [3:0][15:0] re, output logic [3:0][15:0] im,
                             output logic [3:0] last, output logic [3:0] got);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         for (int w = 0; w < 20 && !out_valid; w++) @(negedge clk);
         got[i]  = out_valid;
         re[i]   = out_re;
         im[i]   = out_im;
         last[i] = out_last;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      #12;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b exp 0", out_last); else pass_cnt++;
      total_cnt++; if (out_re !== 16'd0) $display("FAIL reset_out_re: got %0d exp 0", $signed(out_re)); else pass_cnt++;
      total_cnt++; if (out_im !== 16'd0) $display("FAIL reset_out_im: got %0d exp 0", $signed(out_im)); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_impulse;
      logic [3:0][15:0] xr, xi, yr, yi;
      logic [3:0]       yl, yg;
      xr = '0; xi = '0; xr[0] = 16'd4000;
      send_frame(xr, xi);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL impulse_lat_c0: out_valid got %b exp 0", out_valid); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL impulse_lat_c1: out_valid got %b exp 0", out_valid); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL impulse_lat_c2: out_valid got %b exp 1", out_valid); else pass_cnt++;
      recv_frame(yr, yi, yl, yg);
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (yg[i] !== 1'b1 || yr[i] !== 16'd1000 || yi[i] !== 16'd0 || yl[i] !== (i == 3))
            $display("FAIL impulse[%0d]: got v=%b (%0d,%0d) last=%b exp (1000,0) last=%0d",
                     i, yg[i], $signed(yr[i]), $signed(yi[i]), yl[i], i == 3);
         else pass_cnt++;
      end
   endtask

   task automatic test_single_bin;
      logic [3:0][15:0] xr, xi, yr, yi, er, ei;
      logic [3:0]       yl, yg;
      xr = '0; xi = '0; xr[1] = 16'd4000;
      er[0] = 16'd1000; ei[0] = 16'd0;
      er[1] = 16'd0;    ei[1] = 16'd1000;
      er[2] = -16'sd1000; ei[2] = 16'd0;
      er[3] = 16'd0;    ei[3] = -16'sd1000;
      send_frame(xr, xi);
      recv_frame(yr, yi, yl, yg);
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (yg[i] !== 1'b1 || yr[i] !== er[i] || yi[i] !== ei[i] || yl[i] !== (i == 3))
            $display("FAIL single_bin[%0d]: got v=%b (%0d,%0d) last=%b exp (%0d,%0d)",
                     i, yg[i], $signed(yr[i]), $signed(yi[i]), yl[i], $signed(er[i]), $signed(ei[i]));
         else pass_cnt++;
      end
   endtask

   task automatic test_full_scale;
      logic [3:0][15:0] xr, xi, yr, yi, er, ei;
      logic [3:0]       yl, yg;
      for (int i = 0; i < 4; i++) begin
         xr[i] = 16'h8000; xi[i] = 16'h8000;
         er[i] = 16'd0;    ei[i] = 16'd0;
      end
      er[0] = 16'h8000; ei[0] = 16'h8000;
      send_frame(xr, xi);
      recv_frame(yr, yi, yl, yg);
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (yg[i] !== 1'b1 || yr[i] !== er[i] || yi[i] !== ei[i])
            $display("FAIL full_scale[%0d]: got v=%b (%0d,%0d) exp (%0d,%0d)",
                     i, yg[i], $signed(yr[i]), $signed(yi[i]), $signed(er[i]), $signed(ei[i]));
         else pass_cnt++;
      end
   endtask

   task automatic test_truncation;
      logic [3:0][15:0] xr, xi, yr, yi;
      logic [3:0]       yl, yg;
      xr = '0; xi = '0; xr[0] = 16'd3; xi[0] = -16'sd3;
      send_frame(xr, xi);
      recv_frame(yr, yi, yl, yg);
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (yg[i] !== 1'b1 || yr[i] !== 16'd0 || yi[i] !== 16'hFFFF)
            $display("FAIL truncation[%0d]: got v=%b (%0d,%0d) exp (0,-1)",
                     i, yg[i], $signed(yr[i]), $signed(yi[i]));
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure;
      logic [3:0][15:0] xr, xi, yr, yi, er, ei;
      logic [3:0]       yl, yg;
      xr = '0; xi = '0; xr[1] = 16'd4000;
      er[0] = 16'd1000; ei[0] = 16'd0;
      er[1] = 16'd0;    ei[1] = 16'd1000;
      er[2] = -16'sd1000; ei[2] = 16'd0;
      er[3] = 16'd0;    ei[3] = -16'sd1000;
      out_ready = 1'b0;
      send_frame(xr, xi);
      for (int w = 0; w < 20 && !out_valid; w++) @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; in_re = 16'h1234; in_im = 16'h4321;
         total_cnt++;
         if (out_valid !== 1'b1 || out_re !== 16'd1000 || out_im !== 16'd0 || out_last !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL bp_hold[%0d]: got v=%b (%0d,%0d) last=%b rdy=%b exp v=1 (1000,0) last=0 rdy=0",
                     c, out_valid, $signed(out_re), $signed(out_im), out_last, in_ready);
         else pass_cnt++;
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (out_valid !== 1'b1 || out_re !== er[i] || out_im !== ei[i] || out_last !== (i == 3))
            $display("FAIL bp_drain[%0d]: got v=%b (%0d,%0d) last=%b exp (%0d,%0d)",
                     i, out_valid, $signed(out_re), $signed(out_im), out_last, $signed(er[i]), $signed(ei[i]));
         else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL bp_reload: got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
      else pass_cnt++;
      // A follow-up impulse frame exposes any sample or index slip from the ignored pulses.
      xr = '0; xi = '0; xr[0] = 16'd4000;
      send_frame(xr, xi);
      recv_frame(yr, yi, yl, yg);
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (yg[i] !== 1'b1 || yr[i] !== 16'd1000 || yi[i] !== 16'd0 || yl[i] !== (i == 3))
            $display("FAIL bp_next[%0d]: got v=%b (%0d,%0d) last=%b exp (1000,0)",
                     i, yg[i], $signed(yr[i]), $signed(yi[i]), yl[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid_unload;
      logic [3:0][15:0] xr, xi, yr, yi;
      logic [3:0]       yl, yg;
      xr = '0; xi = '0; xr[1] = 16'd4000;
      send_frame(xr, xi);
      for (int w = 0; w < 20 && !out_valid; w++) @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1 || out_re !== 16'd1000)
         $display("FAIL rst_pre: got v=%b re=%0d exp v=1 re=1000", out_valid, $signed(out_re));
      else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_re !== 16'd0 || out_last !== 1'b0)
         $display("FAIL rst_async: got v=%b rdy=%b re=%0d last=%b exp v=0 rdy=1 re=0 last=0",
                  out_valid, in_ready, $signed(out_re), out_last);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      xr = '0; xi = '0; xr[0] = 16'd4000;
      send_frame(xr, xi);
      recv_frame(yr, yi, yl, yg);
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (yg[i] !== 1'b1 || yr[i] !== 16'd1000 || yi[i] !== 16'd0 || yl[i] !== (i == 3))
            $display("FAIL rst_next[%0d]: got v=%b (%0d,%0d) last=%b exp (1000,0)",
                     i, yg[i], $signed(yr[i]), $signed(yi[i]), yl[i]);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset;
      test_impulse;
      test_single_bin;
      test_full_scale;
      test_truncation;
      test_backpressure;
      test_reset_mid_unload;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ifft_point_4_seq.md
# ifft_point_4_seq

Clocked 4-point radix-2 inverse FFT. It accepts one complex 16-bit sample per cycle over a valid/ready stream, buffers a 4-sample frame, and computes the inverse transform in two butterfly stages. It then streams the 4 time-domain samples out in natural order. It is the inverse counterpart of the 4-point forward FFT and reconstructs frames produced by that block, including 1/N scaling.

## Interface
- DATA_W, 16, width of each real/imag component (signed two's complement)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample (high only in LOAD)
- in_re  in  DATA_W  input frequency bin, real part
- in_im  in  DATA_W  input frequency bin, imaginary part
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output sample
- out_re  out  DATA_W  output time sample, real part
- out_im  out  DATA_W  output time sample, imaginary part
- out_last  out  1  high with the 4th (n=3) output sample

## Operation
- FSM states: LOAD, STG1, STG2, UNLOAD.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready handshake writes X[idx] and increments a 2-bit idx.
  - Input order is natural: X0, X1, X2, X3.
  - The handshake at idx=3 wraps idx to 0 and moves to STG1.
- STG1 (one cycle), computed at 17-bit width, each result arithmetic-shifted right by 1 (truncation toward −inf), then stored back at DATA_W:
  - A0=(X0+X2)>>>1
  - A1=(X0−X2)>>>1
  - B0=(X1+X3)>>>1
  - B1=(X1−X3)>>>1
  - Then go to STG2.
- STG2 (one cycle), with jB1=(−B1.im, B1.re), same 17-bit/>>>1 rule:
  - x0=(A0+B0)>>>1
  - x2=(A0−B0)>>>1
  - x1=(A1+jB1)>>>1
  - x3=(A1−jB1)>>>1
  - Then go to UNLOAD.
- Result: x[n] = (1/4)·Σ X[k]·e^{+j2πnk/4}, with no overflow possible for any input.
- UNLOAD:
  - out_valid=1; out_re/out_im present x[odx], odx starting at 0.
  - On out_valid&&out_ready, odx increments.
  - out_last=1 when odx=3; the handshake at odx=3 returns to LOAD.
- in_valid outside LOAD is ignored; no sample is stored.
- out_ready outside UNLOAD is ignored.

## Timing
- Reset values:
  - state=LOAD, idx=odx=0, in_ready=1.
  - out_valid=0, out_last=0, out_re=out_im=0.
  - All sample/stage registers 0.
- All outputs are registered or decoded from registered state; there is no combinational in→out path.
- Latency: 4th input accepted at edge T. STG1 occupies cycle T..T+1, STG2 T+1..T+2, and out_valid rises after edge T+2 (2 cycles after the last input handshake).
- Back-to-back operation: after the out_last handshake, in_ready is high in the next cycle. Minimum frame period is 10 cycles (4 load + 2 compute + 4 unload).
- Backpressure: while out_valid && !out_ready, out_re/out_im/out_last hold stable.
- Input stalls: in_valid low in LOAD pauses idx; partial frames are held indefinitely.
- Reset mid-operation (any state): the frame is discarded and all reset values apply immediately (asynchronously). The first handshake after reset release is X0.

## Structure
- Shared package `fft_pkg`:
  - DATA_W default
  - complex struct typedef {re, im}
  - FSM state enum
  - the >>>1 scaled add/sub helper function
- Sub-module `ifft_bf2`: a combinational radix-2 butterfly with inverse twiddle select.
  - tw=0 gives twiddle 1; tw=1 gives twiddle +j.
  - Outputs (a+w·b)>>>1 and (a−w·b)>>>1.
  - Instantiated twice for STG1 (tw=0) and twice for STG2 (A0/B0 tw=0; A1/B1 tw=1), with results registered by the top.

## Test plan
- Impulse, X=(4000,0),(0,0),(0,0),(0,0) -> outputs (1000,0) ×4; out_last only on 4th; out_valid 2 cycles after 4th handshake.
- Single bin, X1=(4000,0), others 0 -> (1000,0),(0,1000),(−1000,0),(0,−1000).
- Full-scale negative, all X=(−32768,−32768) -> x0=(−32768,−32768), x1..x3=(0,0); no wrap.
- Truncation, X0=(3,−3), others 0 -> all four outputs (0,−1).
- Backpressure and ignored input:
  - out_ready low 5 cycles on first output -> data stable, in_ready=0.
  - in_valid pulses during UNLOAD are ignored.
  - Then 4 outputs drain in 4 cycles and in_ready=1 the next cycle.
- Reset mid-UNLOAD after 2 outputs -> out_valid=0, in_ready=1 immediately; the next full frame (the impulse case) yields (1000,0) ×4.
